// File: rtl/alien_bomb_if.sv
// Bus between the alien bomb engine and the game/video logic around it.
interface alien_bomb_if;
  logic       enable;
  logic [9:0] gunPosition;
  logic [9:0] alienBottomY;
  logic [7:0] alienColsAlive;
  logic [9:0] hPos;
  logic [9:0] vPos;
  logic [1:0] bombAlive;
  logic       shipHit;
  logic [2:0] colorBomb;

  modport master (
    output enable, gunPosition, alienBottomY, alienColsAlive, hPos, vPos,
    input  bombAlive, shipHit, colorBomb
  );

  modport slave (
    input  enable, gunPosition, alienBottomY, alienColsAlive, hPos, vPos,
    output bombAlive, shipHit, colorBomb
  );
endinterface

// File: rtl/alien_bomb.sv
// Enemy projectile engine: two bomb slots spawned under living alien columns,
// falling once per frame tick, with ship impact detection and pixel colouring.
module alien_bomb #(
  parameter int unsigned SCREEN_HEIGHT = 480,
  parameter int unsigned SHIP_WIDTH    = 60,
  parameter int unsigned SHIP_HEIGHT   = 30,
  parameter int unsigned V_OFFSET      = 10,
  parameter int unsigned BOMB_W        = 4,
  parameter int unsigned BOMB_H        = 10,
  parameter int unsigned STEP_MOTION   = 2,
  parameter int unsigned FIRE_INTERVAL = 120,
  parameter int unsigned ALIEN_X0      = 64,
  parameter int unsigned ALIEN_SPACING = 64,
  parameter int unsigned BOMB          = 4,
  parameter int unsigned BACKGROUND    = 0
) (
  input  logic         clk,
  input  logic         reset,
  alien_bomb_if.slave  bus
);

  localparam int unsigned SHIP_TOP = SCREEN_HEIGHT - V_OFFSET - SHIP_HEIGHT;
  localparam int unsigned FLOOR_Y  = SCREEN_HEIGHT - V_OFFSET;
  localparam int unsigned CD_W     = (FIRE_INTERVAL < 1) ? 1 : $clog2(FIRE_INTERVAL + 1);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [1:0]       r_alive;
  logic [1:0][9:0]  r_x;
  logic [1:0][9:0]  r_y;
  logic [CD_W-1:0]  r_cooldown;
  logic [15:0]      r_lfsr;
  logic             r_ship_hit;

  logic [15:0]      w_lfsr_next;
  logic [15:0]      w_cols2;
  logic [7:0]       w_rot;
  logic [2:0]       w_off;
  logic [2:0]       w_col;
  logic [9:0]       w_spawn_x;
  logic             w_free_any;
  logic             w_free_slot;
  logic             w_spawn;
  logic [1:0][10:0] w_ny;
  logic [1:0][10:0] w_bot;
  logic [1:0]       w_in_x;
  logic [1:0]       w_hit;
  logic [1:0]       w_land;
  logic [1:0]       w_pix;
  logic [10:0]      w_gun_lo;
  logic [10:0]      w_gun_hi;

  assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

  // Rotate the column mask so bit 0 is the LFSR start column; lowest set bit wins.
  assign w_cols2 = {bus.alienColsAlive, bus.alienColsAlive};
  assign w_rot   = 8'(w_cols2 >> r_lfsr[2:0]);

  always_comb begin
    w_off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_rot[i]) w_off = 3'(i);
    end
  end

  assign w_col       = r_lfsr[2:0] + w_off;
  assign w_spawn_x   = 10'(ALIEN_X0 + ALIEN_SPACING * 32'(w_col));
  assign w_free_any  = ~&r_alive;
  assign w_free_slot = r_alive[0];
  assign w_spawn     = bus.enable && (r_cooldown == '0) &&
                       (bus.alienColsAlive != 8'd0) && w_free_any;

  // Ship horizontal window; lower bound in signed arithmetic so a gun near x=0 does not wrap.
  assign w_gun_lo = 11'({1'b0, bus.gunPosition}) - 11'(SHIP_WIDTH / 2);
  assign w_gun_hi = 11'({1'b0, bus.gunPosition}) + 11'(SHIP_WIDTH / 2);

  always_comb begin
    w_ny   = '0;
    w_bot  = '0;
    w_in_x = '0;
    w_hit  = '0;
    w_land = '0;
    for (int s = 0; s < 2; s++) begin
      w_ny[s]   = 11'({1'b0, r_y[s]}) + 11'(STEP_MOTION);
      w_bot[s]  = w_ny[s] + 11'(BOMB_H);
      w_in_x[s] = ($signed({1'b0, r_x[s]}) >= $signed(w_gun_lo)) &&
                  (11'({1'b0, r_x[s]}) <= w_gun_hi);
      w_hit[s]  = r_alive[s] && (w_bot[s] >= 11'(SHIP_TOP)) && w_in_x[s];
      w_land[s] = r_alive[s] && !w_hit[s] && (w_bot[s] >= 11'(FLOOR_Y));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_alive    <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_cooldown <= CD_W'(FIRE_INTERVAL);
      r_lfsr     <= LFSR_SEED;
      r_ship_hit <= 1'b0;
    end else begin
      r_lfsr     <= w_lfsr_next;
      r_ship_hit <= 1'b0;
      if (bus.enable) begin
        r_ship_hit <= |w_hit;
        for (int s = 0; s < 2; s++) begin
          if (w_hit[s] || w_land[s]) begin
            r_alive[s] <= 1'b0;
            r_x[s]     <= '0;
            r_y[s]     <= '0;
          end else if (r_alive[s]) begin
            r_y[s] <= w_ny[s][9:0];
          end
        end
        // Spawn targets a slot that was free before this tick, so it never collides with motion.
        if (w_spawn) begin
          r_alive[w_free_slot] <= 1'b1;
          r_x[w_free_slot]     <= w_spawn_x;
          r_y[w_free_slot]     <= bus.alienBottomY + 10'd1;
        end
        if (r_cooldown != '0) begin
          r_cooldown <= r_cooldown - CD_W'(1);
        end else if (w_spawn) begin
          r_cooldown <= CD_W'(FIRE_INTERVAL);
        end
      end
    end
  end

  // Pixel path: zero latency from hPos/vPos against registered slot state.
  always_comb begin
    w_pix = '0;
    for (int s = 0; s < 2; s++) begin
      w_pix[s] = r_alive[s] &&
                 (11'({1'b0, bus.hPos}) >= 11'({1'b0, r_x[s]}) - 11'(BOMB_W / 2)) &&
                 (11'({1'b0, bus.hPos}) <  11'({1'b0, r_x[s]}) + 11'(BOMB_W / 2)) &&
                 (11'({1'b0, bus.vPos}) >= 11'({1'b0, r_y[s]})) &&
                 (11'({1'b0, bus.vPos}) <  11'({1'b0, r_y[s]}) + 11'(BOMB_H));
    end
  end

  assign bus.colorBomb = (|w_pix) ? 3'(BOMB) : 3'(BACKGROUND);
  assign bus.bombAlive = r_alive;
  assign bus.shipHit   = r_ship_hit;

endmodule

// File: tb/tb_alien_bomb.sv
// Randomized bench for alien_bomb against a behavioural slot/cooldown model.
module tb_alien_bomb;

  localparam int FI       = 3;
  localparam int SHIP_TOP = 440;
  localparam int FLOOR_Y  = 470;

  logic clk = 1'b0;
  logic reset;

  always #10 clk = ~clk;

  alien_bomb_if bus ();

  alien_bomb #(.FIRE_INTERVAL(FI)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          m_alive [2];
  int          m_x     [2];
  int          m_y     [2];
  int          m_cd;
  int          m_hit;
  logic [15:0] m_lfsr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pix_exp(input int h, input int v);
    for (int s = 0; s < 2; s++) begin
      if (m_alive[s] != 0 && h >= m_x[s] - 2 && h < m_x[s] + 2 &&
          v >= m_y[s] && v < m_y[s] + 10)
        return 4;
    end
    return 0;
  endfunction

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    logic [15:0] nl;
    int was [2];
    int hit_any;
    int gun;
    int start;
    int col;
    int found;
    int ny;
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        m_alive[s] = 0; m_x[s] = 0; m_y[s] = 0;
      end
      m_cd   = FI;
      m_lfsr = 16'hACE1;
      m_hit  = 0;
      return;
    end
    nl = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    if (bus.enable) begin
      gun     = int'(bus.gunPosition);
      hit_any = 0;
      for (int s = 0; s < 2; s++) was[s] = m_alive[s];
      for (int s = 0; s < 2; s++) begin
        if (was[s] != 0) begin
          ny = m_y[s] + 2;
          if (ny + 10 >= SHIP_TOP && gun - 30 <= m_x[s] && m_x[s] <= gun + 30) begin
            m_alive[s] = 0; m_x[s] = 0; m_y[s] = 0; hit_any = 1;
          end else if (ny + 10 >= FLOOR_Y) begin
            m_alive[s] = 0; m_x[s] = 0; m_y[s] = 0;
          end else begin
            m_y[s] = ny;
          end
        end
      end
      if (m_cd > 0) begin
        m_cd--;
      end else if (bus.alienColsAlive != 8'd0 && (was[0] == 0 || was[1] == 0)) begin
        start = int'(m_lfsr[2:0]);
        found = 0;
        col   = 0;
        for (int k = 0; k < 8; k++) begin
          if (found == 0 && bus.alienColsAlive[(start + k) % 8]) begin
            col = (start + k) % 8; found = 1;
          end
        end
        begin
          int slot;
          slot = (was[0] == 0) ? 0 : 1;
          m_alive[slot] = 1;
          m_x[slot]     = 64 + 64 * col;
          m_y[slot]     = (int'(bus.alienBottomY) + 1) % 1024;
        end
        m_cd = FI;
      end
      m_hit = hit_any;
    end else begin
      m_hit = 0;
    end
    m_lfsr = nl;
  endtask

  task automatic probe(input string tag, input int h, input int v);
    bus.hPos = 10'(h);
    bus.vPos = 10'(v);
    #1;
    check(tag, 32'(bus.colorBomb), 32'(pix_exp(h, v)));
  endtask

  // One clock: update model, let the DUT clock, then compare on the falling edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("bombAlive", 32'(bus.bombAlive), 32'({m_alive[1] != 0, m_alive[0] != 0}));
    check("shipHit", 32'(bus.shipHit), 32'(m_hit));
    for (int s = 0; s < 2; s++) begin
      if (m_alive[s] != 0) begin
        probe("pix_in", m_x[s] - 2 + int'($urandom_range(0, 3)), m_y[s] + int'($urandom_range(0, 9)));
        probe("pix_right", m_x[s] + 2, m_y[s]);
        probe("pix_below", m_x[s] - 1, m_y[s] + 10);
      end
    end
    probe("pix_rand", int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
  endtask

  function automatic logic [9:0] pick_gun();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 2) return 10'($urandom_range(0, 40));
    if (r < 3) return 10'($urandom_range(600, 1023));
    return 10'(64 + 64 * int'($urandom_range(0, 7)) + int'($urandom_range(0, 70)) - 35);
  endfunction

  initial begin
    reset              = 1'b1;
    bus.enable         = 1'b0;
    bus.gunPosition    = 10'd500;
    bus.alienBottomY   = 10'd200;
    bus.alienColsAlive = 8'b0000_0100;
    bus.hPos           = '0;
    bus.vPos           = '0;
    @(negedge clk);
    cycle();
    cycle();

    // Spawn timing with a single column, then a bomb that misses the ship.
    reset      = 1'b0;
    bus.enable = 1'b1;
    for (int i = 0; i < 150; i++) cycle();

    // No spawns while the formation reports no columns, then column 0 only.
    bus.alienColsAlive = 8'h00;
    for (int i = 0; i < 10; i++) cycle();
    bus.alienColsAlive = 8'h01;
    for (int i = 0; i < 20; i++) cycle();

    // Ship under column 2 so bombs strike it.
    bus.alienColsAlive = 8'b0000_0100;
    bus.gunPosition    = 10'd192;
    for (int i = 0; i < 250; i++) cycle();

    // Reset with bombs in flight.
    reset = 1'b1;
    cycle();
    reset = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      bus.enable = ($urandom_range(0, 3) != 0);
      reset      = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 49) == 0) bus.gunPosition = pick_gun();
      if ($urandom_range(0, 79) == 0)
        bus.alienColsAlive = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 99) == 0) bus.alienBottomY = 10'($urandom_range(100, 300));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
    $finish;
  end

endmodule
